lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter: SIZE, 128, memory depth in 32-bit words; legal word index 0..SIZE-1.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req_valid  input  1  core access request.
REQ-005 SHALL have port: req_ready  output  1  controller accepts request this cycle.
REQ-006 SHALL have port: req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port: req_funct3  input  3  RV32I load/store funct3.
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port: rsp_valid  output  1  one-cycle completion pulse, no backpressure.
REQ-011 SHALL have port: rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 SHALL have port: rsp_err  output  1  access rejected, qualified by rsp_valid.
REQ-013 SHALL have port: mem_addr  output  32  word-aligned byte address to memory read/write port.
REQ-014 SHALL have port: mem_rdata  input  32  memory read data, valid one cycle after mem_addr is sampled.
REQ-015 SHALL have port: mem_we  output  1  memory word write enable.
REQ-016 SHALL have port: mem_wdata  output  32  full word to write.
REQ-017 SHALL have port: mem_sel  output  3  constant 3'b010; all memory accesses are whole words.

Function
REQ-018 SHALL implement FSM states IDLE, RD, CAP, WR, RESP; req_ready=1 only in IDLE with rst=0.
REQ-019 SHALL capture we/funct3/addr/wdata on req_valid&&req_ready (cycle N); no request is accepted elsewhere.
REQ-020 SHALL drive mem_addr={addr[31:2],2'b00} from the captured address in RD and WR; 0 otherwise.
REQ-021 SHALL sequence loads: IDLE(N) -> RD(N+1) -> CAP(N+2, sample mem_rdata) -> RESP(N+3, rsp_valid=1) -> IDLE.
REQ-022 SHALL sequence SW: IDLE(N) -> WR(N+1, mem_we=1, mem_wdata=wdata) -> RESP(N+2) -> IDLE.
REQ-023 SHALL sequence SB/SH as read-modify-write: IDLE -> RD -> CAP (merge into register) -> WR (N+3, mem_we=1) -> RESP (N+4).
REQ-024 SHALL use little-endian lanes: byte k = bits [8k+7:8k], k=addr[1:0]; halfword at addr[1]=0 bits [15:0], else [31:16].
REQ-025 SHALL merge SB by replacing only byte lane addr[1:0] with wdata[7:0], SH by replacing only halfword lane addr[1] with wdata[15:0]; other lanes keep read value.
REQ-026 SHALL extract loads: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-027 SHALL flag error when: funct3 not in {0,1,2,4,5} for load or not in {0,1,2} for store; halfword with addr[0]=1; word with addr[1:0]!=0; addr[31:2]>=SIZE.
REQ-028 SHALL on error skip memory entirely (mem_we never 1): IDLE(N) -> RESP(N+1) with rsp_err=1, rsp_rdata=0.
REQ-029 SHALL hold rsp_valid high for exactly one cycle per accepted request, rsp_err/rsp_rdata valid only that cycle, 0 otherwise.
REQ-030 SHALL keep mem_we=0 in every state except WR; mem_wdata=0 when mem_we=0.
REQ-031 SHALL permit back-to-back requests: new request accepted in the IDLE cycle immediately after RESP.

Reset
REQ-032 SHALL on rst=1 at a clock edge enter IDLE and clear all captured registers, rsp_valid, rsp_err, rsp_rdata to 0.
REQ-033 SHALL gate mem_we, req_ready combinationally with !rst so an in-flight WR issues no write when rst=1 that cycle.
REQ-034 SHALL discard any in-flight request on reset with no rsp_valid generated for it.

Verification
REQ-035 SHALL test LW: mem[4]=0x8081_7F01, load funct3=2 addr=0x10 -> rsp_valid at N+3, rsp_rdata=0x8081_7F01, rsp_err=0.
REQ-036 SHALL test LB/LBU: same word, LB addr=0x13 -> 0xFFFF_FF80; LBU addr=0x13 -> 0x0000_0080; LH addr=0x12 -> 0xFFFF_8081.
REQ-037 SHALL test SB RMW: mem[4]=0x1122_3344, SB addr=0x11 wdata=0xAB -> mem_we at N+3 with mem_wdata=0x1122_AB44, rsp_valid at N+4.
REQ-038 SHALL test errors: LW addr=0x12, SH addr=0x11, LW addr=0x200 (SIZE=128), load funct3=3 -> each rsp_valid at N+1, rsp_err=1, no mem_we.
REQ-039 SHALL test reset mid-RMW: SH issued, rst=1 in WR cycle -> mem_we=0, no rsp_valid, req_ready=1 first cycle after rst falls.
REQ-040 SHALL test back-to-back SW addr=0x0 then LW addr=0x0 with req_valid held -> second accepted cycle after first RESP, returns stored data.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: bundles the core request/response handshake and the
// single-port word memory bus of the load/store controller.
//   req_*  : core access request (valid/ready, we, funct3, byte addr, wdata)
//   rsp_*  : one-cycle completion pulse with extended load data and error
//   mem_*  : word-aligned memory read/write port (rdata one cycle latency)
// Modports:
//   slave  : the controller
//   master : the environment (core + memory)
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_sel;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_we, mem_wdata, mem_sel
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_we, mem_wdata, mem_sel
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store unit front-end to a word-wide memory.
// Loads read a word and extract/extend the addressed byte/halfword; SW
// writes directly; SB/SH do read-modify-write. Misaligned, illegal-funct3
// and out-of-range accesses complete without touching memory.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset
//   bus  : lsu_mem_ctrl_if.slave (request, response and memory signals)
// Parameter:
//   SIZE : memory depth in 32-bit words
module lsu_mem_ctrl #(
  parameter int unsigned SIZE = 128
) (
  input  logic          clk,
  input  logic          rst,
  lsu_mem_ctrl_if.slave bus
);

  localparam logic [31:0] SizeW = 32'(SIZE);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic        ready;
  logic        accept;
  logic        req_err;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign ready  = (state_q == IDLE) && !rst;
  assign accept = bus.req_valid && ready;

  // Request legality check on the incoming request fields.
  always_comb begin
    req_err = 1'b0;
    if (bus.req_we) begin
      if (bus.req_funct3 > 3'd2) req_err = 1'b1;
    end else begin
      case (bus.req_funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: req_err = req_err;
        default:                      req_err = 1'b1;
      endcase
    end
    if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
      req_err = 1'b1;
    if ((bus.req_funct3 == 3'd2) && (bus.req_addr[1:0] != 2'b00))
      req_err = 1'b1;
    if ({2'b00, bus.req_addr[31:2]} >= SizeW)
      req_err = 1'b1;
  end

  // Lane extraction and merge, both keyed off the captured address.
  always_comb begin
    rd_byte   = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    rd_half   = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    load_val  = bus.mem_rdata;
    case (funct3_q)
      3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
      3'd4:    load_val = {24'h0, rd_byte};
      3'd5:    load_val = {16'h0, rd_half};
      default: load_val = bus.mem_rdata;
    endcase
    merge_val = bus.mem_rdata;
    if (funct3_q[1:0] == 2'b00)
      merge_val[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    else
      merge_val[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
  end

  // State register and captured request/data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath update.
  // data_q first holds the store data; CAP overwrites it with either the
  // extended load result or the merged RMW word.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          data_d   = bus.req_wdata;
          err_d    = req_err;
          if (req_err)
            state_d = RESP;
          else if (bus.req_we && (bus.req_funct3 == 3'd2))
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        data_d  = we_q ? merge_val : load_val;
        state_d = we_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; write enable and ready are masked by rst in the same cycle.
  always_comb begin
    bus.req_ready = ready;
    bus.mem_sel   = 3'b010;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = '0;
    if ((state_q == RD) || (state_q == WR))
      bus.mem_addr = {addr_q[31:2], 2'b00};
    if ((state_q == WR) && !rst) begin
      bus.mem_we    = 1'b1;
      bus.mem_wdata = data_q;
    end
    if ((state_q == RESP) && !rst) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_err   = err_q;
      if (!err_q && !we_q)
        bus.rsp_rdata = data_q;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: table-driven directed bench for lsu_mem_ctrl with a
// behavioural one-cycle-latency word memory, plus hand sequences for reset
// during a read-modify-write and back-to-back requests.
module tb_lsu_mem_ctrl;
  localparam int unsigned SIZE = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [SIZE];
  logic        pre_we;
  logic [6:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) begin
    if (pre_we)
      mem[pre_idx] <= pre_val;
    else if (bus.mem_we)
      mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[8:2]];
  end

  typedef struct {
    logic        pre_en;
    logic [6:0]  pre_idx;
    logic [31:0] pre_val;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          we_cyc;
    logic [31:0] we_data;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%08h exp=0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [6:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_we  = 1'b1;
    @(negedge clk);
    pre_we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, we_seen, we_cnt, dirty;
    logic [31:0] r_data, w_data, w_addr;
    logic r_err;
    int r1, r2, acc;
    logic [31:0] r2_data;
    logic r1_err;

    // pre, idx, val, we, f3, addr, wdata, lat, rdata, err, we_cyc, we_data
    vecs[0]  = '{1'b1, 7'd4,   32'h8081_7F01, 1'b0, 3'd2, 32'h10,  32'h0,  3, 32'h8081_7F01, 1'b0, 0, 32'h0};
    vecs[1]  = '{1'b0, 7'd0,   32'h0,         1'b0, 3'd0, 32'h13,  32'h0,  3, 32'hFFFF_FF80, 1'b0, 0, 32'h0};
    vecs[2]  = '{1'b0, 7'd0,   32'h0,         1'b0, 3'd4, 32'h13,  32'h0,  3, 32'h0000_0080, 1'b0, 0, 32'h0};
    vecs[3]  = '{1'b0, 7'd0,   32'h0,         1'b0, 3'd1, 32'h12,  32'h0,  3, 32'hFFFF_8081, 1'b0, 0, 32'h0};
    vecs[4]  = '{1'b0, 7'd0,   32'h0,         1'b0, 3'd5, 32'h10,  32'h0,  3, 32'h0000_7F01, 1'b0, 0, 32'h0};
    vecs[5]  = '{1'b0, 7'd0,   32'h0,         1'b0, 3'd0, 32'h11,  32'h0,  3, 32'h0000_007F, 1'b0, 0, 32'h0};
    vecs[6]  = '{1'b1, 7'd4,   32'h1122_3344, 1'b1, 3'd0, 32'h11,  32'hAB, 4, 32'h0,         1'b0, 3, 32'h1122_AB44};
    vecs[7]  = '{1'b0, 7'd0,   32'h0,         1'b1, 3'd1, 32'h12,  32'hDEAD_BEEF, 4, 32'h0,  1'b0, 3, 32'hBEEF_AB44};
    vecs[8]  = '{1'b0, 7'd0,   32'h0,         1'b0, 3'd2, 32'h10,  32'h0,  3, 32'hBEEF_AB44, 1'b0, 0, 32'h0};
    vecs[9]  = '{1'b0, 7'd0,   32'h0,         1'b1, 3'd2, 32'h14,  32'hCAFE_F00D, 2, 32'h0,  1'b0, 1, 32'hCAFE_F00D};
    vecs[10] = '{1'b0, 7'd0,   32'h0,         1'b0, 3'd2, 32'h14,  32'h0,  3, 32'hCAFE_F00D, 1'b0, 0, 32'h0};
    vecs[11] = '{1'b1, 7'd127, 32'h5A5A_0001, 1'b0, 3'd2, 32'h1FC, 32'h0,  3, 32'h5A5A_0001, 1'b0, 0, 32'h0};
    vecs[12] = '{1'b0, 7'd0,   32'h0,         1'b0, 3'd2, 32'h12,  32'h0,  1, 32'h0,         1'b1, 0, 32'h0};
    vecs[13] = '{1'b0, 7'd0,   32'h0,         1'b1, 3'd1, 32'h11,  32'h1234, 1, 32'h0,       1'b1, 0, 32'h0};
    vecs[14] = '{1'b0, 7'd0,   32'h0,         1'b0, 3'd2, 32'h200, 32'h0,  1, 32'h0,         1'b1, 0, 32'h0};
    vecs[15] = '{1'b0, 7'd0,   32'h0,         1'b0, 3'd3, 32'h10,  32'h0,  1, 32'h0,         1'b1, 0, 32'h0};
    vecs[16] = '{1'b0, 7'd0,   32'h0,         1'b1, 3'd4, 32'h10,  32'h55, 1, 32'h0,         1'b1, 0, 32'h0};
    vecs[17] = '{1'b0, 7'd0,   32'h0,         1'b0, 3'd5, 32'h13,  32'h0,  1, 32'h0,         1'b1, 0, 32'h0};
    vecs[18] = '{1'b0, 7'd0,   32'h0,         1'b1, 3'd0, 32'h1FF, 32'h77, 4, 32'h0,         1'b0, 3, 32'h775A_0001};

    rst            = 1'b1;
    pre_we         = 1'b0;
    pre_idx        = '0;
    pre_val        = '0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    repeat (3) @(negedge clk);
    chk("ready_during_rst", {31'h0, bus.req_ready}, 32'h0);
    rst = 1'b0;
    #1;
    chk("reset_ready",     {31'h0, bus.req_ready}, 32'h1);
    chk("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("reset_mem_we",    {31'h0, bus.mem_we},    32'h0);
    chk("reset_mem_addr",  bus.mem_addr,           32'h0);
    chk("reset_rsp_rdata", bus.rsp_rdata,          32'h0);
    chk("mem_sel",         {29'h0, bus.mem_sel},   32'h2);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].pre_en) preload(vecs[i].pre_idx, vecs[i].pre_val);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {31'h0, bus.req_ready}, 32'h1);
      bus.req_valid  = 1'b1;
      bus.req_we     = vecs[i].we;
      bus.req_funct3 = vecs[i].f3;
      bus.req_addr   = vecs[i].addr;
      bus.req_wdata  = vecs[i].wdata;
      @(posedge clk);
      lat = 0; we_seen = 0; we_cnt = 0; dirty = 0;
      r_data = '0; r_err = 1'b0; w_data = '0; w_addr = '0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (k == 1) bus.req_valid = 1'b0;
        if (bus.mem_we) begin
          we_seen = k; we_cnt++;
          w_data = bus.mem_wdata; w_addr = bus.mem_addr;
        end
        if (!bus.rsp_valid && (bus.rsp_err || (bus.rsp_rdata != 32'h0))) dirty = 1;
        if (bus.rsp_valid) begin
          lat = k; r_data = bus.rsp_rdata; r_err = bus.rsp_err;
          break;
        end
      end
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_rdata", i), r_data, vecs[i].rdata);
      chk($sformatf("v%0d_err", i), {31'h0, r_err}, {31'h0, vecs[i].err});
      chk($sformatf("v%0d_we_cycle", i), we_seen, vecs[i].we_cyc);
      chk($sformatf("v%0d_we_count", i), we_cnt, (vecs[i].we_cyc != 0) ? 1 : 0);
      chk($sformatf("v%0d_quiet_outputs", i), dirty, 0);
      if (vecs[i].we_cyc != 0) begin
        chk($sformatf("v%0d_we_data", i), w_data, vecs[i].we_data);
        chk($sformatf("v%0d_we_addr", i), w_addr, vecs[i].addr & 32'hFFFF_FFFC);
      end
    end

    // Reset asserted during the write cycle of a halfword RMW.
    preload(7'd8, 32'h0102_0304);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd1;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h5555;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmw_we_before_rst", {31'h0, bus.mem_we}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rmw_we_in_rst",    {31'h0, bus.mem_we},    32'h0);
    chk("rmw_ready_in_rst", {31'h0, bus.req_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmw_ready_after_rst", {31'h0, bus.req_ready}, 32'h1);
    chk("rmw_rsp_after_rst",   {31'h0, bus.rsp_valid}, 32'h0);
    we_cnt = 0; lat = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) lat++;
      if (bus.mem_we) we_cnt++;
    end
    chk("rmw_no_rsp", lat, 0);
    chk("rmw_no_we", we_cnt, 0);
    chk("rmw_mem_untouched", mem[8], 32'h0102_0304);

    // Back-to-back SW then LW with req_valid held high.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h1357_9BDF;
    @(posedge clk);
    r1 = 0; r2 = 0; acc = 0; r2_data = '0; r1_err = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        if (r1 == 0) begin
          r1 = k; r1_err = bus.rsp_err;
        end else begin
          r2 = k; r2_data = bus.rsp_rdata;
        end
      end
      if (k == 1) begin
        bus.req_we    = 1'b0;
        bus.req_wdata = 32'h0;
      end
      if ((acc != 0) && (k == acc + 1)) bus.req_valid = 1'b0;
      if (bus.req_ready && (acc == 0)) acc = k;
      if (r2 != 0) break;
    end
    bus.req_valid = 1'b0;
    chk("b2b_first_rsp", r1, 2);
    chk("b2b_first_err", {31'h0, r1_err}, 32'h0);
    chk("b2b_accept", acc, 3);
    chk("b2b_second_rsp", r2, 6);
    chk("b2b_rdata", r2_data, 32'h1357_9BDF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
